// File: rtl/fsm_pulse_driver.sv
// Pulse-count handshake initiator: emits PULSE_COUNT single-cycle pulses with a
// programmable gap, then checks that the counter's completion flag lands on time.
module fsm_pulse_driver #(
    parameter int PULSE_COUNT = 5,
    parameter int CNT_W       = 3,
    parameter int GAP_W       = 4,
    parameter int TIMEOUT     = 8
) (
    input  logic             Clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [GAP_W-1:0] gap,
    input  logic             ack_in,
    output logic             drv_out,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] pulse_cnt
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PULSE_COUNT - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, PULSE, GAP, WAIT_ACK, DONE, ERR} state_t;

    state_t             state, state_d;
    logic [GAP_W-1:0]   gap_r, gap_r_d;
    logic [GAP_W-1:0]   gap_cnt, gap_cnt_d;
    logic [TMO_W-1:0]   tmo_cnt, tmo_cnt_d;
    logic [CNT_W-1:0]   pulse_cnt_d;
    logic               last_pulse;

    assign last_pulse = (pulse_cnt == LAST_IDX);

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d     = state;
        gap_r_d     = gap_r;
        gap_cnt_d   = gap_cnt;
        tmo_cnt_d   = tmo_cnt;
        pulse_cnt_d = pulse_cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    gap_r_d     = gap;
                    pulse_cnt_d = '0;
                    state_d     = PULSE;
                end
            end
            PULSE: begin
                pulse_cnt_d = pulse_cnt + CNT_W'(1);
                if (ack_in) begin
                    state_d = last_pulse ? DONE : ERR;
                end else if (last_pulse) begin
                    state_d   = WAIT_ACK;
                    tmo_cnt_d = '0;
                end else if (gap_r == '0) begin
                    state_d = PULSE;
                end else begin
                    // Count down gap_r-1 .. 0 so GAP lasts exactly gap_r cycles.
                    state_d   = GAP;
                    gap_cnt_d = gap_r - GAP_W'(1);
                end
            end
            GAP: begin
                if (ack_in)              state_d = ERR;
                else if (gap_cnt == '0)  state_d = PULSE;
                else                     gap_cnt_d = gap_cnt - GAP_W'(1);
            end
            WAIT_ACK: begin
                if (ack_in)                  state_d = DONE;
                else if (tmo_cnt == TMO_LAST) state_d = ERR;
                else                         tmo_cnt_d = tmo_cnt + TMO_W'(1);
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gap_r     <= '0;
            gap_cnt   <= '0;
            tmo_cnt   <= '0;
            pulse_cnt <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            state     <= state_d;
            gap_r     <= gap_r_d;
            gap_cnt   <= gap_cnt_d;
            tmo_cnt   <= tmo_cnt_d;
            pulse_cnt <= pulse_cnt_d;
        end
    end

    // Outputs decode only the state register, so ack_in never reaches them combinationally.
    assign drv_out = (state == PULSE);
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign err     = (state == ERR);

endmodule

// File: tb/tb_fsm_pulse_driver.sv
// Directed self-checking bench for fsm_pulse_driver, with a small Mealy 5-pulse
// counter model that can be swapped for a forced ack level.
module tb_fsm_pulse_driver;

    localparam int NCYC = 32;

    logic       Clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] gap;
    logic       ack_in;
    logic       drv_out, busy, done, err;
    logic [2:0] pulse_cnt;

    logic       ack_mode;   // 1: counter model drives ack, 0: ack_force drives it
    logic       ack_force;
    logic [2:0] model_cnt;

    int passed = 0;
    int total  = 0;

    logic       drv_h  [0:NCYC];
    logic       busy_h [0:NCYC];
    logic       done_h [0:NCYC];
    logic       err_h  [0:NCYC];
    logic [2:0] pc_h   [0:NCYC];

    fsm_pulse_driver #(.PULSE_COUNT(5), .CNT_W(3), .GAP_W(4), .TIMEOUT(8)) dut (
        .Clk       (Clk),
        .rst_n     (rst_n),
        .start     (start),
        .gap       (gap),
        .ack_in    (ack_in),
        .drv_out   (drv_out),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .pulse_cnt (pulse_cnt)
    );

    always #5 Clk = ~Clk;

    // Reference 5-state counter: ack is asserted combinationally during the 5th pulse.
    always @(posedge Clk or negedge rst_n) begin
        if (!rst_n)       model_cnt <= 3'd0;
        else if (drv_out) model_cnt <= (model_cnt == 3'd4) ? 3'd0 : model_cnt + 3'd1;
    end
    assign ack_in = ack_mode ? (drv_out && model_cnt == 3'd4) : ack_force;

    task automatic chk(input string name, input int cyc, input logic [2:0] got, input logic [2:0] exp);
        total++;
        if (got !== exp)
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, got, exp);
        else
            passed++;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; start = 1'b0; gap = 4'd0; ack_force = 1'b0; ack_mode = 1'b1;
        repeat (2) @(negedge Clk);
        rst_n = 1'b1;
        @(negedge Clk);
    endtask

    // Cycle 0 is the cycle in which start is first sampled; history index c is cycle c.
    task automatic capture(input int n, input logic [3:0] g, input logic hold,
                           input int force_c, input int gap_chg_c);
        @(negedge Clk);
        gap = g; start = 1'b1;
        for (int c = 1; c <= n; c++) begin
            @(negedge Clk);
            drv_h[c] = drv_out; busy_h[c] = busy; done_h[c] = done;
            err_h[c] = err;     pc_h[c]   = pulse_cnt;
            if (!hold) start = 1'b0;
            ack_force = (c == force_c);
            if (c == gap_chg_c) gap = 4'd0;
        end
        start = 1'b0; ack_force = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; gap = 4'd0; ack_force = 1'b0; ack_mode = 1'b1;
        #1;
        chk("rst_drv", 0, {2'b0, drv_out}, 3'd0);
        chk("rst_busy", 0, {2'b0, busy}, 3'd0);
        chk("rst_done", 0, {2'b0, done}, 3'd0);
        chk("rst_err", 0, {2'b0, err}, 3'd0);
        chk("rst_pcnt", 0, pulse_cnt, 3'd0);
        apply_reset();
    endtask

    task automatic test_gap0();
        apply_reset();
        capture(9, 4'd0, 1'b0, 0, 0);
        for (int c = 1; c <= 9; c++) begin
            chk("g0_drv",  c, {2'b0, drv_h[c]},  {2'b0, c <= 5});
            chk("g0_done", c, {2'b0, done_h[c]}, {2'b0, c == 6});
            chk("g0_err",  c, {2'b0, err_h[c]},  3'd0);
            chk("g0_busy", c, {2'b0, busy_h[c]}, {2'b0, c <= 6});
        end
        chk("g0_pcnt_mid", 3, pc_h[3], 3'd2);
        chk("g0_pcnt_end", 8, pc_h[8], 3'd5);
    endtask

    task automatic test_gap2();
        apply_reset();
        // gap input is zeroed in cycle 2; the latched gap of 2 must still apply.
        capture(16, 4'd2, 1'b0, 0, 2);
        for (int c = 1; c <= 16; c++) begin
            chk("g2_drv",  c, {2'b0, drv_h[c]},
                {2'b0, (c == 1 || c == 4 || c == 7 || c == 10 || c == 13)});
            chk("g2_done", c, {2'b0, done_h[c]}, {2'b0, c == 14});
            chk("g2_err",  c, {2'b0, err_h[c]},  3'd0);
            chk("g2_busy", c, {2'b0, busy_h[c]}, {2'b0, c <= 14});
        end
        chk("g2_pcnt", 15, pc_h[15], 3'd5);
    endtask

    task automatic test_timeout();
        apply_reset();
        ack_mode = 1'b0;
        capture(16, 4'd0, 1'b0, 0, 0);
        for (int c = 1; c <= 16; c++) begin
            chk("to_drv",  c, {2'b0, drv_h[c]},  {2'b0, c <= 5});
            chk("to_err",  c, {2'b0, err_h[c]},  {2'b0, c == 14});
            chk("to_done", c, {2'b0, done_h[c]}, 3'd0);
            chk("to_busy", c, {2'b0, busy_h[c]}, {2'b0, c <= 14});
        end
        chk("to_pcnt", 15, pc_h[15], 3'd5);
    endtask

    task automatic test_premature();
        apply_reset();
        ack_mode = 1'b0;
        capture(8, 4'd0, 1'b0, 2, 0);
        for (int c = 1; c <= 8; c++) begin
            chk("pm_drv",  c, {2'b0, drv_h[c]},  {2'b0, c <= 2});
            chk("pm_err",  c, {2'b0, err_h[c]},  {2'b0, c == 3});
            chk("pm_done", c, {2'b0, done_h[c]}, 3'd0);
            chk("pm_busy", c, {2'b0, busy_h[c]}, {2'b0, c <= 3});
        end
        chk("pm_pcnt", 5, pc_h[5], 3'd2);
    endtask

    task automatic test_reset_mid();
        logic seen;
        apply_reset();
        @(negedge Clk);
        gap = 4'd2; start = 1'b1;
        @(negedge Clk); start = 1'b0;   // cycle 1: PULSE
        @(negedge Clk);                 // cycle 2: GAP
        chk("rm_in_gap_drv",  2, {2'b0, drv_out}, 3'd0);
        chk("rm_in_gap_busy", 2, {2'b0, busy},    3'd1);
        chk("rm_in_gap_pcnt", 2, pulse_cnt,       3'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rm_async_drv",  2, {2'b0, drv_out}, 3'd0);
        chk("rm_async_busy", 2, {2'b0, busy},    3'd0);
        chk("rm_async_pcnt", 2, pulse_cnt,       3'd0);
        @(negedge Clk); rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge Clk);
            if (done || err || busy) seen = 1'b1;
        end
        chk("rm_quiet", 0, {2'b0, seen}, 3'd0);
        capture(8, 4'd0, 1'b0, 0, 0);
        for (int c = 1; c <= 8; c++) begin
            chk("rm_drv",  c, {2'b0, drv_h[c]},  {2'b0, c <= 5});
            chk("rm_done", c, {2'b0, done_h[c]}, {2'b0, c == 6});
            chk("rm_err",  c, {2'b0, err_h[c]},  3'd0);
        end
        chk("rm_pcnt", 7, pc_h[7], 3'd5);
    endtask

    task automatic test_back_to_back();
        apply_reset();
        capture(8, 4'd0, 1'b1, 0, 0);   // start held high for cycles 0-8
        for (int c = 1; c <= 8; c++) begin
            chk("bb_drv",  c, {2'b0, drv_h[c]},  {2'b0, (c <= 5 || c == 8)});
            chk("bb_done", c, {2'b0, done_h[c]}, {2'b0, c == 6});
            chk("bb_busy", c, {2'b0, busy_h[c]}, {2'b0, c != 7});
        end
        // Second transaction began in cycle 8; its done lands in cycle 13.
        for (int c = 9; c <= 15; c++) begin
            @(negedge Clk);
            chk("bb2_drv",  c, {2'b0, drv_out}, {2'b0, c <= 12});
            chk("bb2_done", c, {2'b0, done},    {2'b0, c == 13});
            chk("bb2_err",  c, {2'b0, err},     3'd0);
            chk("bb2_busy", c, {2'b0, busy},    {2'b0, c <= 13});
        end
    endtask

    initial begin
        test_reset();
        test_gap0();
        test_gap2();
        test_timeout();
        test_premature();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/fsm_pulse_driver.md
Name: fsm_pulse_driver

Overview:
- Initiator end of the pulse-count handshake: drives the count input of a pulse-counting cycle detector and checks its one-cycle completion flag.
- On a start command it emits PULSE_COUNT single-cycle pulses, with a programmable idle gap between pulses.
- It then reports done when the completion flag arrives at the right time, or err when the flag is early or late.
- Used as the local stimulus/self-check source next to the counter FSM in the FSM library.

Parameters:
- PULSE_COUNT, 5, pulses per transaction (>=1; must equal the counter's cycle length).
- CNT_W, 3, width of the pulse counter (2^CNT_W > PULSE_COUNT).
- GAP_W, 4, width of the gap field.
- TIMEOUT, 8, maximum cycles to wait for ack after the last pulse (>=1).

Ports:
- Clk  input  1  clock, posedge active.
- rst_n  input  1  asynchronous reset, active-low.
- start  input  1  begin a transaction; sampled only in IDLE.
- gap  input  GAP_W  idle cycles between pulses; latched on accepted start.
- ack_in  input  1  completion flag from the counter (may be combinational/Mealy).
- drv_out  output  1  pulse stream to the counter input.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle success strobe.
- err  output  1  one-cycle failure strobe.
- pulse_cnt  output  CNT_W  pulses issued in the current transaction.

Behaviour:
- One clock. Reset is asynchronous and active-low. Clock and reset ports are named Clk and rst_n.
- Reset (asynchronous, any state): state=IDLE; drv_out=0, busy=0, done=0, err=0, pulse_cnt=0; gap and timeout registers cleared.
- All outputs decode from registers; no combinational input-to-output path.
- States: IDLE, PULSE, GAP, WAIT_ACK, DONE, ERR.
- drv_out=1 only in PULSE. done=1 only in DONE. err=1 only in ERR.
- IDLE: start=1 at an edge latches gap_r=gap, clears pulse_cnt, goes to PULSE. start=0 stays. ack_in is ignored.
- PULSE lasts exactly one cycle; pulse_cnt increments at its end. Transitions are evaluated on the ack_in sampled in this cycle:
  - ack_in=1 and this is pulse PULSE_COUNT: go to DONE. This is the normal case for a Mealy counter.
  - ack_in=1 on an earlier pulse: go to ERR (premature).
  - ack_in=0 and this is the last pulse: go to WAIT_ACK.
  - ack_in=0, not the last pulse, gap_r=0: go to PULSE (back-to-back pulses).
  - ack_in=0, not the last pulse, gap_r>0: go to GAP.
- GAP: drv_out=0 for exactly gap_r cycles, then PULSE. ack_in=1 in any GAP cycle goes to ERR.
- WAIT_ACK: at most TIMEOUT cycles. ack_in=1 in any of them goes to DONE. No ack by the TIMEOUT-th cycle goes to ERR. The timeout counter clears on entry.
- DONE and ERR each last one cycle, then IDLE. busy stays 1 in them. pulse_cnt holds its final value until the next accepted start.
- start while busy: ignored, never queued. start in the DONE/ERR cycle is also ignored.
- Latency with gap=g and ack on the last pulse:
  - first pulse in the cycle after start is sampled;
  - pulse k in cycle 1+(k-1)(g+1);
  - done in the cycle after the last pulse.
- gap changes after start have no effect on the transaction in progress.
- Reset mid-transaction aborts immediately: no done or err is produced. The next start begins a fresh transaction.

Test Plan:
- Connected to the reference-style 5-state counter, gap=0, start at cycle 0 -> drv_out high cycles 1-5; done=1 in cycle 6; err never asserts; pulse_cnt=5; busy falls in cycle 7.
- Same setup with gap=2 -> pulses in cycles 1, 4, 7, 10, 13; done in cycle 14; drv_out=0 in every gap cycle.
- ack_in tied 0, gap=0, TIMEOUT=8 -> pulses in cycles 1-5; WAIT_ACK in cycles 6-13; err=1 in cycle 14; done stays 0.
- ack_in forced high during the 2nd pulse, gap=0 -> err=1 in cycle 3; no further pulses; pulse_cnt=2.
- rst_n pulsed low during a GAP cycle -> drv_out/busy/pulse_cnt go to 0 asynchronously; no done or err; a start after release gives a clean 5-pulse transaction ending in done.
- start held high through a whole transaction -> exactly one transaction per IDLE visit; the second transaction's first pulse falls 2 cycles after done.
